// File: rtl/microc_pkg.sv
// Shared constants for the microc_gen datapath.
// Holds opcode width and ALU function encodings.
package microc_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_NOTA  = 3'd1;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;
  localparam logic [2:0] ALU_NEGA  = 3'd6;
  localparam logic [2:0] ALU_NEGB  = 3'd7;

endpackage

// File: rtl/microc_alu.sv
// Combinational ALU for microc_gen.
// Results wrap modulo 2^DW.
module microc_alu
  import microc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    alu_op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    unique case (alu_op)
      ALU_PASSA: y = a;
      ALU_NOTA:  y = ~a;
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_NEGA:  y = '0 - a;
      ALU_NEGB:  y = '0 - b;
    endcase
  end

endmodule

// File: rtl/microc_gen.sv
// Parametrised single-cycle microcontroller datapath.
// Return-address stack enabled by defining MICROC_STACK_EN.
module microc_gen
  import microc_pkg::*;
#(
  parameter int DW          = 8,
  parameter int NREG        = 16,
  parameter int PCW         = 10,
  parameter int IW          = 16,
  parameter int STACK_DEPTH = 4,
  localparam int RAW = $clog2(NREG),
  localparam int SLW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PCW-1:0]      imem_addr,
  input  logic [IW-1:0]       imem_data,
  output logic [OPCODE_W-1:0] opcode,
  output logic                zero,
  input  logic                s_inc,
  input  logic                s_inm,
  input  logic                we,
  input  logic                wez,
  input  logic [2:0]          alu_op,
  input  logic                push,
  input  logic                pop,
  output logic [SLW-1:0]      stack_lvl,
  output logic                stack_err
);

  logic [PCW-1:0] pc, pc_inc, pc_seq, pc_nxt, target;
  logic [RAW-1:0] ra1, ra2, wa;
  logic [DW-1:0]  imm, a, b, alu_y, wdata;
  logic [DW-1:0]  rf [NREG];

  assign opcode = imem_data[IW-1 -: OPCODE_W];
  assign ra1    = imem_data[3*RAW-1 -: RAW];
  assign ra2    = imem_data[2*RAW-1 -: RAW];
  assign wa     = imem_data[RAW-1:0];
  assign imm    = imem_data[RAW+DW-1:RAW];
  assign target = imem_data[PCW-1:0];

  assign a = (ra1 == '0) ? '0 : rf[ra1];
  assign b = (ra2 == '0) ? '0 : rf[ra2];

  microc_alu #(.DW(DW)) u_alu (
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .y      (alu_y)
  );

  assign wdata     = s_inm ? imm : alu_y;
  assign pc_inc    = pc + PCW'(1);
  assign pc_seq    = s_inc ? pc_inc : target;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      zero <= 1'b0;
      pc   <= '0;
    end else begin
      if (we && wa != '0) rf[wa] <= wdata;
      if (wez) zero <= (alu_y == '0);
      pc <= pc_nxt;
    end
  end

`ifdef MICROC_STACK_EN
  logic [PCW-1:0] stk [STACK_DEPTH];
  logic [SLW-1:0] lvl, lvl_nxt;
  logic           err, err_nxt, do_push, do_pop;

  always_comb begin
    pc_nxt  = pc_seq;
    lvl_nxt = lvl;
    err_nxt = err;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (push && pop) begin
      pc_nxt  = pc_inc;
      err_nxt = 1'b1;
    end else if (pop) begin
      if (lvl != '0) begin
        pc_nxt  = stk[0];
        lvl_nxt = lvl - SLW'(1);
        do_pop  = 1'b1;
      end else begin
        pc_nxt  = pc_inc;
        err_nxt = 1'b1;
      end
    end else if (push) begin
      pc_nxt = target;
      if (lvl != SLW'(STACK_DEPTH)) begin
        lvl_nxt = lvl + SLW'(1);
        do_push = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl <= '0;
      err <= 1'b0;
    end else begin
      lvl <= lvl_nxt;
      err <= err_nxt;
    end
  end

  // Shift-register stack: top of stack is always entry 0
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      stk[0] <= pc_inc;
      for (int i = 1; i < STACK_DEPTH; i++)
        stk[i] <= stk[i-1];
    end else if (!reset && do_pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++)
        stk[i] <= stk[i+1];
    end
  end

  assign stack_lvl = lvl;
  assign stack_err = err;
`else
  logic unused_stack;

  assign unused_stack = push ^ pop;
  assign pc_nxt       = pc_seq;
  assign stack_lvl    = '0;
  assign stack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_microc_gen.sv
// Self-checking bench for microc_gen against a behavioural model.
// Stack checks run only when MICROC_STACK_EN is defined.
module tb_microc_gen;

`ifdef MICROC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam int C_INC = 1;
  localparam int C_INM = 2;
  localparam int C_WE  = 4;
  localparam int C_WEZ = 8;
  localparam int C_PU  = 16;
  localparam int C_PO  = 32;
  localparam int C_RS  = 64;

  logic        clk = 1'b0;
  logic        reset, s_inc, s_inm, we, wez, push, pop;
  logic [2:0]  alu_op;
  logic [15:0] idata;
  logic [17:0] idata_w;
  logic [9:0]  addr, addr_w;
  logic [5:0]  opc, opc_w;
  logic        zero, zero_w, err, err_w;
  logic [2:0]  lvl, lvl_w;

  int n_cmp = 0;
  int n_err = 0;

  int m_pc;
  int m_z;
  int m_err;
  int m_r [16];
  int m_q [$];

  always #5 clk = ~clk;

  assign idata_w = {2'b00, idata};

  microc_gen u_dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (addr),
    .imem_data (idata),
    .opcode    (opc),
    .zero      (zero),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .we        (we),
    .wez       (wez),
    .alu_op    (alu_op),
    .push      (push),
    .pop       (pop),
    .stack_lvl (lvl),
    .stack_err (err)
  );

  microc_gen #(.DW(12), .IW(18)) u_wide (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (addr_w),
    .imem_data (idata_w),
    .opcode    (opc_w),
    .zero      (zero_w),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .we        (we),
    .wez       (wez),
    .alu_op    (alu_op),
    .push      (push),
    .pop       (pop),
    .stack_lvl (lvl_w),
    .stack_err (err_w)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input int ins, input int op, input int c);
    int a, b, y, wa, tgt, inc1;
    a    = m_r[(ins >> 8) & 15];
    b    = m_r[(ins >> 4) & 15];
    wa   = ins & 15;
    tgt  = ins & 1023;
    inc1 = (m_pc + 1) % 1024;
    case (op)
      0: y = a;
      1: y = ~a;
      2: y = a + b;
      3: y = a - b;
      4: y = a & b;
      5: y = a | b;
      6: y = -a;
      default: y = -b;
    endcase
    y &= 255;
    if (c & C_RS) begin
      m_pc = 0; m_z = 0; m_err = 0;
      foreach (m_r[i]) m_r[i] = 0;
      m_q.delete();
      return;
    end
    if ((c & C_WE) && wa != 0)
      m_r[wa] = (c & C_INM) ? ((ins >> 4) & 255) : y;
    if (c & C_WEZ) m_z = (y == 0);
    if (STK && (c & C_PU) && (c & C_PO)) begin
      m_pc = inc1; m_err = 1;
    end else if (STK && (c & C_PO)) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = inc1; m_err = 1; end
    end else if (STK && (c & C_PU)) begin
      if (m_q.size() < 4) m_q.push_back(inc1);
      else m_err = 1;
      m_pc = tgt;
    end else begin
      m_pc = (c & C_INC) ? inc1 : tgt;
    end
  endtask

  task automatic step(input string tag, input int ins, input int op,
                      input int c);
    idata  = 16'(ins);
    alu_op = 3'(op);
    s_inc  = (c & C_INC) != 0;
    s_inm  = (c & C_INM) != 0;
    we     = (c & C_WE) != 0;
    wez    = (c & C_WEZ) != 0;
    push   = (c & C_PU) != 0;
    pop    = (c & C_PO) != 0;
    reset  = (c & C_RS) != 0;
    #1;
    check({tag, ".opc"}, int'(opc), (ins >> 10) & 63);
    model(ins, op, c);
    @(posedge clk);
    #1;
    check({tag, ".pc"}, int'(addr), m_pc);
    check({tag, ".z"}, int'(zero), m_z);
    check({tag, ".lvl"}, int'(lvl), m_q.size());
    check({tag, ".err"}, int'(err), m_err);
  endtask

  initial begin
    int ins, c, op;
    m_pc = 0; m_z = 0; m_err = 0;
    foreach (m_r[i]) m_r[i] = 0;

    step("rst0", int'($urandom), int'($urandom_range(0, 7)),
         int'($urandom_range(0, 63)) | C_RS);
    step("rst1", int'($urandom), int'($urandom_range(0, 7)),
         int'($urandom_range(0, 63)) | C_RS);
    check("rst.pc", int'(addr), 0);
    check("rst.z", int'(zero), 0);
    check("rst.lvl", int'(lvl), 0);
    check("rst.err", int'(err), 0);

    step("li3", (3 << 4) | 4, 0, C_INC | C_INM | C_WE);
    step("sub", (4 << 8) | (4 << 4) | 5, 3, C_INC | C_WE | C_WEZ);
    check("sub.zero", int'(zero), 1);
    step("add", (4 << 8) | 6, 2, C_INC | C_WE | C_WEZ);
    check("add.zero", int'(zero), 0);

    step("j5", 5, 0, 0);
    step("j2a", 'h2A, 0, 0);
    check("jmp.pc", int'(addr), 'h2A);
    step("j3ff", 'h3FF, 0, 0);
    step("wrap", 0, 0, C_INC);
    check("wrap.pc", int'(addr), 0);

    if (STK) begin
      step("cj5", 5, 0, 0);
      step("call", 'h100, 0, C_PU);
      check("call.pc", int'(addr), 'h100);
      check("call.lvl", int'(lvl), 1);
      step("ret", 0, 0, C_PO);
      check("ret.pc", int'(addr), 6);
      check("ret.err", int'(err), 0);

      step("r", 0, 0, C_RS);
      for (int i = 0; i < 5; i++)
        step("push5", 'h10 + i, 0, C_PU);
      check("ovf.pc", int'(addr), 'h14);
      check("ovf.lvl", int'(lvl), 4);
      check("ovf.err", int'(err), 1);

      step("r", 0, 0, C_RS);
      step("udf", 'h33, 0, C_PO);
      check("udf.pc", int'(addr), 1);
      check("udf.err", int'(err), 1);

      step("r", 0, 0, C_RS);
      step("both", 'h33, 0, C_PU | C_PO);
      check("both.pc", int'(addr), 1);
      check("both.err", int'(err), 1);
    end

    step("r", 0, 0, C_RS);
    step("liff", ('hFF << 4) | 1, 0, C_INC | C_INM | C_WE);
    step("li1", (1 << 4) | 2, 0, C_INC | C_INM | C_WE);
    step("addw", (1 << 8) | (2 << 4) | 3, 2, C_INC | C_WE | C_WEZ);
    check("w8.zero", int'(zero), 1);
    check("w12.zero", int'(zero_w), 0);
    step("li100", ('h100 << 4) | 7, 0, C_INC | C_INM | C_WE);
    step("cmp", (3 << 8) | (7 << 4) | 8, 3, C_INC | C_WE | C_WEZ);
    check("w8.r3", int'(zero), 1);
    check("w12.r3", int'(zero_w), 1);
    check("w12.pc", int'(addr_w), m_pc);

    for (int i = 0; i < 400; i++) begin
      ins = int'($urandom) & 'hFFFF;
      if ($urandom_range(0, 2) == 0)
        ins = (ins & ~('hF << 4)) | (((ins >> 8) & 15) << 4);
      op = int'($urandom_range(0, 7));
      c  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) c |= C_PU;
      if ($urandom_range(0, 7) == 0) c |= C_PO;
      if ($urandom_range(0, 60) == 0) c |= C_RS;
      step("rnd", ins, op, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/microc_gen.md
# microc_gen

Parametrised single-cycle microcontroller datapath: program counter, register file, ALU, zero flag and an optional return-address stack for subroutine call/return. It generalises the existing `microc` in data width, register count and program space. An external control unit decodes the `opcode` output and drives the control inputs. Instruction memory is external, with a combinational read.

## Interface
Parameters:
- `DW`, 8: data/register width.
- `NREG`, 16: register count, power of two; `RAW = $clog2(NREG)`.
- `PCW`, 10: program counter / instruction address width.
- `IW`, 16: instruction width.
  - Must satisfy `IW >= 6+PCW`, `IW >= RAW+DW` and `IW >= 3*RAW`.
- `STACK_DEPTH`, 4: return-stack entries, at least 1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock, rising edge.
  - `reset`, in, 1: synchronous, active-high.
- Instruction memory:
  - `imem_addr`, out, PCW: current PC.
  - `imem_data`, in, IW: instruction at `imem_addr`.
- Status to the control unit:
  - `opcode`, out, 6: `imem_data[IW-1 -: 6]`, combinational.
  - `zero`, out, 1: registered zero flag.
- Control inputs:
  - `s_inc`, in, 1: 1 selects PC+1; 0 selects the jump target.
  - `s_inm`, in, 1: write data = immediate (1) or ALU result (0).
  - `we`, in, 1: register-file write enable.
  - `wez`, in, 1: zero-flag write enable.
  - `alu_op`, in, 3: ALU function.
  - `push`, in, 1: call; push PC+1 and jump.
  - `pop`, in, 1: return; PC ← top of stack.
- Stack status:
  - `stack_lvl`, out, `$clog2(STACK_DEPTH+1)`: occupied stack entries.
  - `stack_err`, out, 1: sticky overflow/underflow flag.

## Operation
Instruction fields:
- `ra1 = instr[3*RAW-1 -: RAW]`
- `ra2 = instr[2*RAW-1 -: RAW]`
- `wa = instr[RAW-1:0]`
- `imm = instr[RAW+DW-1:RAW]`
- `target = instr[PCW-1:0]`

Register file:
- R0 reads as 0; writes to R0 are ignored.
- `we=1` writes the write data to `wa`, where write data = `s_inm ? imm : alu_result`.

ALU (A = R[ra1], B = R[ra2], result truncated mod 2^DW):
- 000: A
- 001: ~A
- 010: A+B
- 011: A−B
- 100: A&B
- 101: A|B
- 110: −A
- 111: −B

Zero flag: `wez=1` loads `(alu_result == 0)`; otherwise it holds.

PC next-state, in priority order:
1. `reset`: PC ← 0.
2. `push && pop`: PC+1; stack unchanged; `stack_err` set.
3. `pop`:
   - Stack non-empty: PC ← top of stack, `stack_lvl` − 1.
   - Stack empty: PC+1, `stack_err` set.
4. `push`:
   - Stack not full: push PC+1, PC ← `target`, `stack_lvl` + 1.
   - Stack full: PC ← `target`, nothing pushed, `stack_err` set.
5. Otherwise: `s_inc ? PC+1 : target`.

PC+1 wraps modulo 2^PCW.

Reset values:
- PC, `zero`, `stack_lvl`, `stack_err` = 0.
- All registers 0.

`stack_err` clears only on reset. Register writes, flag writes and stack pushes are independent of PC selection and may occur in the same cycle.

## Timing
- Single cycle: all state updates on the rising edge of `clk`; no multi-cycle states.
- `opcode`, the register reads and `alu_result` are combinational from `imem_data` within the cycle.
- No write bypass: a read of a register being written in the same cycle returns the old value. The new value is visible the next cycle.
- `reset` asserted mid-program overrides every write, push and pop in that cycle.
- Latency:
  - `zero` reflects an ALU result one cycle after the `wez` cycle.
  - `imem_addr` changes one cycle after a jump, call or return is presented.

## Configuration
Macro: `MICROC_STACK_EN`.
- Defined: return stack, `push`/`pop` semantics and `stack_err` as above.
- Undefined:
  - No stack storage.
  - `push`/`pop` are ignored; PC follows `s_inc`/`target` only.
  - `stack_lvl` and `stack_err` are tied to 0.

## Structure
- Package `microc_pkg`:
  - `OPCODE_W = 6`.
  - ALU-op localparams: `ALU_PASSA`, `ALU_NOTA`, `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_NEGA`, `ALU_NEGB`.
- Sub-module `microc_alu` (`#(DW)`): combinational ALU.
- Register file, PC logic and stack stay in `microc_gen`.

## Test plan
All scenarios use default parameters unless stated.
- **Reset:** hold `reset` 2 cycles with random control inputs → `imem_addr=0`, `zero=0`, `stack_lvl=0`, `stack_err=0`.
- **Load/ALU/zero:**
  - LI #3,R4 (`s_inm=1`, `we=1`, `imm=3`, `wa=4`).
  - SUB R4,R4,R5 with `wez=1` → `zero=1`.
  - ADD R4,R0,R6 with `wez=1` → `zero=0`.
- **Jump:** at PC 0x005, `s_inc=0`, `target=0x2A` → `imem_addr=0x02A` next cycle. PC at 0x3FF with `s_inc=1` → 0x000.
- **Call/return:**
  - At PC 0x005, `push` with `target=0x100` → PC=0x100, `stack_lvl=1`.
  - `pop` → PC=0x006, `stack_lvl=0`, `stack_err=0`.
- **Stack limits (`STACK_DEPTH=4`):**
  - Five pushes → fifth still jumps, `stack_lvl=4`, `stack_err=1`.
  - After reset, `pop` on empty → PC+1, `stack_err=1`.
  - `push`+`pop` together → PC+1, `stack_err=1`.
- **Width wrap:** LI #0xFF,R1; LI #1,R2; ADD R1,R2,R3 with `wez=1` → R3 = 0x00 and `zero=1`. Repeat with `DW=12`, `IW=18` → R3 = 0x100 and `zero=0`.
